bus_control_unit: RTL and testbench

- Owns the external bus.
- Arbitrates between the prefetch queue (instruction fetch) and execution-unit data commands (mem/IO read/write).
- Sequences one bus cycle at a time: drives address, status, byte enable and write data, waits for active-low readyb, then delivers data to the winner.
- Sits between prefetch_queue / execution_unit and the pins; replaces the ad-hoc bus muxing in the top level.

---
 rtl/bus_control_unit.sv | 183 ++++++++++++++++++
 tb/tb_bus_control_unit.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_control_unit.sv
// rtl/bus_control_unit.sv - external bus sequencer arbitrating prefetch and EU bus cycles
//
// Runs one bus cycle at a time: either an instruction fetch for the prefetch
// queue (FETCH) or a memory/IO command from the execution unit (EU_CYCLE).
// Each cycle is followed by at least one IDLE cycle where arbitration happens.
// Optional feature macro: BUS_TIMEOUT_EN (abort a cycle after TIMEOUT_CYCLES
// wait states; without it cycles wait forever and bus_error is tied 0).
//
// Ports:
//   clk, resetn                 rising-edge clock, synchronous active-low reset
//   PS, PFP                     code segment and prefetch offset (fetch address)
//   queue_full, queue_suspend,
//   queue_flush                 prefetch queue status inputs
//   queue_push, queue_push_byte combinational queue write strobe (+ odd byte flag)
//   eu_bus_command, eu_bus_address, eu_byte_enable_upper, eu_write_data
//                               EU request, held until eu_done
//   eu_read_data, eu_done       captured read data and one-cycle completion pulse
//   data_in, readyb             bus read data, active-low ready
//   address_out, data_out, bus_status, bus_upper_byte_enable
//                               registered bus pins
//   bus_error                   one-cycle timeout pulse
module bus_control_unit #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] PS,
  input  logic [15:0] PFP,
  input  logic        queue_full,
  input  logic        queue_suspend,
  input  logic        queue_flush,
  output logic        queue_push,
  output logic        queue_push_byte,
  input  logic [2:0]  eu_bus_command,
  input  logic [19:0] eu_bus_address,
  input  logic        eu_byte_enable_upper,
  input  logic [15:0] eu_write_data,
  output logic [15:0] eu_read_data,
  output logic        eu_done,
  input  logic [15:0] data_in,
  input  logic        readyb,
  output logic [19:0] address_out,
  output logic [15:0] data_out,
  output logic [3:0]  bus_status,
  output logic        bus_upper_byte_enable,
  output logic        bus_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [3:0] ST_IDLE   = 4'b1111;
  localparam logic [3:0] ST_MEM_RD = 4'b1001;
  localparam logic [3:0] ST_MEM_WR = 4'b1010;
  localparam logic [3:0] ST_IO_RD  = 4'b0101;
  localparam logic [3:0] ST_IO_WR  = 4'b0110;

  typedef enum logic [1:0] {IDLE, FETCH, EU_CYCLE} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          flush_seen;
  logic          byte_only;
  logic          eu_is_read;

  logic       eu_req;
  logic       pf_ok;
  logic       starved;
  logic       grant_eu;
  logic       grant_pf;
  logic [3:0] eu_status;

  always_comb begin
    eu_status = ST_IDLE;
    case (eu_bus_command)
      3'd1:    eu_status = ST_MEM_RD;
      3'd2:    eu_status = ST_MEM_WR;
      3'd3:    eu_status = ST_IO_RD;
      3'd4:    eu_status = ST_IO_WR;
      default: eu_status = ST_IDLE;
    endcase
    // While eu_done is high the EU still shows the command that just finished.
    eu_req   = (eu_status != ST_IDLE) && !eu_done;
    pf_ok    = !queue_full && !queue_suspend && !queue_flush;
    starved  = pf_ok && (starve_cnt >= SW'(STARVE_LIMIT));
    grant_pf = (state == IDLE) && pf_ok && (starved || !eu_req);
    grant_eu = (state == IDLE) && eu_req && !starved;
  end

  // A flush at any point of the fetch discards the word; reset abandons it.
  assign queue_push      = resetn && (state == FETCH) && !readyb && !flush_seen && !queue_flush;
  assign queue_push_byte = queue_push && byte_only;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_cnt;
`else
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                 <= IDLE;
      address_out           <= 20'hFFFF0;
      bus_status            <= ST_IDLE;
      data_out              <= 16'h0000;
      bus_upper_byte_enable <= 1'b0;
      eu_done               <= 1'b0;
      eu_read_data          <= 16'h0000;
      starve_cnt            <= '0;
      flush_seen            <= 1'b0;
      byte_only             <= 1'b0;
      eu_is_read            <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      bus_error             <= 1'b0;
      wait_cnt              <= '0;
`endif
    end else begin
      eu_done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      bus_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_eu) begin
            state                 <= EU_CYCLE;
            address_out           <= eu_bus_address;
            bus_status            <= eu_status;
            bus_upper_byte_enable <= eu_byte_enable_upper;
            eu_is_read            <= (eu_bus_command == 3'd1) || (eu_bus_command == 3'd3);
            if ((eu_bus_command == 3'd2) || (eu_bus_command == 3'd4))
              data_out <= eu_write_data;
            // starved is false here, so the counter is below the limit
            if (pf_ok)
              starve_cnt <= starve_cnt + 1'b1;
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else if (grant_pf) begin
            state                 <= FETCH;
            address_out           <= {PS, 4'h0} + {4'h0, PFP};
            bus_status            <= ST_MEM_RD;
            bus_upper_byte_enable <= 1'b1;
            byte_only             <= PFP[0];
            flush_seen            <= 1'b0;
            starve_cnt            <= '0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        FETCH, EU_CYCLE: begin
          if (queue_flush)
            flush_seen <= 1'b1;
          if (!readyb) begin
            state      <= IDLE;
            bus_status <= ST_IDLE;
            if (state == EU_CYCLE) begin
              eu_done <= 1'b1;
              if (eu_is_read)
                eu_read_data <= data_in;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state      <= IDLE;
            bus_status <= ST_IDLE;
            bus_error  <= 1'b1;
            if (state == EU_CYCLE) begin
              eu_done      <= 1'b1;
              eu_read_data <= 16'hFFFF;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_unit.sv
// tb/tb_bus_control_unit.sv - self-checking bench for bus_control_unit
module tb_bus_control_unit;

  localparam int STARVE = 4;
  localparam int TMO    = 16;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] PS, PFP;
  logic        queue_full, queue_suspend, queue_flush;
  logic        queue_push, queue_push_byte;
  logic [2:0]  eu_bus_command;
  logic [19:0] eu_bus_address;
  logic        eu_byte_enable_upper;
  logic [15:0] eu_write_data, eu_read_data;
  logic        eu_done;
  logic [15:0] data_in;
  logic        readyb;
  logic [19:0] address_out;
  logic [15:0] data_out;
  logic [3:0]  bus_status;
  logic        bus_upper_byte_enable, bus_error;

  bus_control_unit dut (
    .clk(clk), .resetn(resetn), .PS(PS), .PFP(PFP),
    .queue_full(queue_full), .queue_suspend(queue_suspend), .queue_flush(queue_flush),
    .queue_push(queue_push), .queue_push_byte(queue_push_byte),
    .eu_bus_command(eu_bus_command), .eu_bus_address(eu_bus_address),
    .eu_byte_enable_upper(eu_byte_enable_upper), .eu_write_data(eu_write_data),
    .eu_read_data(eu_read_data), .eu_done(eu_done),
    .data_in(data_in), .readyb(readyb),
    .address_out(address_out), .data_out(data_out), .bus_status(bus_status),
    .bus_upper_byte_enable(bus_upper_byte_enable), .bus_error(bus_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding bus transaction plus the visible pin values.
  typedef struct {
    bit active;
    bit fetch;
    bit rd;
    bit dropped;
    bit byte_only;
    int waits;
  } txn_t;

  txn_t        cur;
  logic [19:0] m_addr;
  logic [15:0] m_dout, m_rdata;
  logic [3:0]  m_status;
  logic        m_upper, m_done, m_err;
  int          m_starve;

  function automatic logic [3:0] cmd_status(input logic [2:0] c);
    case (c)
      3'd1:    return 4'b1001;
      3'd2:    return 4'b1010;
      3'd3:    return 4'b0101;
      3'd4:    return 4'b0110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic void model_step();
    bit eu_wants, pf_ok;
    logic [31:0] a;
    if (!resetn) begin
      cur = '{active: 1'b0, fetch: 1'b0, rd: 1'b0, dropped: 1'b0, byte_only: 1'b0, waits: 0};
      m_addr = 20'hFFFF0; m_status = 4'hF; m_dout = 16'h0; m_upper = 1'b0;
      m_done = 1'b0; m_rdata = 16'h0; m_err = 1'b0; m_starve = 0;
      return;
    end
    eu_wants = (cmd_status(eu_bus_command) != 4'hF) && !m_done;
    pf_ok    = !queue_full && !queue_suspend && !queue_flush;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (cur.active) begin
      if (queue_flush) cur.dropped = 1'b1;
      if (!readyb) begin
        cur.active = 1'b0;
        m_status = 4'hF;
        if (!cur.fetch) begin
          m_done = 1'b1;
          if (cur.rd) m_rdata = data_in;
        end
      end else begin
        cur.waits++;
        if (TMO_EN && cur.waits >= TMO) begin
          cur.active = 1'b0;
          m_status = 4'hF;
          m_err = 1'b1;
          if (!cur.fetch) begin
            m_done = 1'b1;
            m_rdata = 16'hFFFF;
          end
        end
      end
    end else if (pf_ok && (m_starve >= STARVE || !eu_wants)) begin
      cur = '{active: 1'b1, fetch: 1'b1, rd: 1'b0, dropped: 1'b0, byte_only: PFP[0], waits: 0};
      a = (32'(PS) * 32'd16 + 32'(PFP)) % 32'h0010_0000;
      m_addr = a[19:0];
      m_status = 4'b1001;
      m_upper = 1'b1;
      m_starve = 0;
    end else if (eu_wants) begin
      cur = '{active: 1'b1, fetch: 1'b0, rd: (eu_bus_command == 3'd1 || eu_bus_command == 3'd3),
              dropped: 1'b0, byte_only: 1'b0, waits: 0};
      m_addr = eu_bus_address;
      m_status = cmd_status(eu_bus_command);
      m_upper = eu_byte_enable_upper;
      if (!cur.rd) m_dout = eu_write_data;
      if (pf_ok) m_starve++;
    end
  endfunction

  task automatic settle();
    logic exp_push;
    #1;
    exp_push = resetn && cur.active && cur.fetch && !readyb && !cur.dropped && !queue_flush;
    check("address_out", 32'(address_out), 32'(m_addr));
    check("bus_status", 32'(bus_status), 32'(m_status));
    check("data_out", 32'(data_out), 32'(m_dout));
    check("bus_upper_byte_enable", 32'(bus_upper_byte_enable), 32'(m_upper));
    check("eu_done", 32'(eu_done), 32'(m_done));
    check("eu_read_data", 32'(eu_read_data), 32'(m_rdata));
    check("bus_error", 32'(bus_error), 32'(m_err));
    check("queue_push", 32'(queue_push), 32'(exp_push));
    check("queue_push_byte", 32'(queue_push_byte), 32'(exp_push && cur.byte_only));
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    check("reset_address", 32'(address_out), 32'h000FFFF0);
    check("reset_status", 32'(bus_status), 32'hF);
    tick();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [15:0] ps;
    logic [15:0] pfp;
    int          waits;
    logic [19:0] addr;
    logic        bytef;
  } fvec_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        upper;
    logic [15:0] rdata;
    int          waits;
    logic [3:0]  status;
  } evec_t;

  fvec_t       fv[5];
  evec_t       ev[4];
  logic [15:0] rd;

  initial begin
    fv[0] = '{16'hFFFF, 16'h0000, 1, 20'hFFFF0, 1'b0};
    fv[1] = '{16'h0000, 16'h0003, 0, 20'h00003, 1'b1};
    fv[2] = '{16'h1234, 16'h5678, 2, 20'h179B8, 1'b0};
    fv[3] = '{16'hF000, 16'hFFFF, 0, 20'hFFFFF, 1'b1};
    fv[4] = '{16'hFFFF, 16'h0011, 3, 20'h00001, 1'b1};
    ev[0] = '{3'd2, 20'h12345, 16'hBEEF, 1'b1, 16'h0000, 0, 4'b1010};
    ev[1] = '{3'd1, 20'hABCDE, 16'h1111, 1'b0, 16'h5A5A, 1, 4'b1001};
    ev[2] = '{3'd3, 20'h003F8, 16'h2222, 1'b1, 16'h1234, 2, 4'b0101};
    ev[3] = '{3'd4, 20'h00060, 16'h55AA, 1'b0, 16'h0000, 0, 4'b0110};

    resetn = 1'b0; PS = 16'h0; PFP = 16'h0;
    queue_full = 1'b1; queue_suspend = 1'b0; queue_flush = 1'b0;
    eu_bus_command = 3'd0; eu_bus_address = 20'h0; eu_byte_enable_upper = 1'b0;
    eu_write_data = 16'h0; data_in = 16'h0; readyb = 1'b1;
    model_step();
    @(negedge clk);
    do_reset();

    // fetch vectors; first one starts right out of reset
    for (int i = 0; i < 5; i++) begin
      PS = fv[i].ps; PFP = fv[i].pfp; queue_full = 1'b0; readyb = 1'b1;
      tick();
      queue_full = 1'b1;
      for (int w = 0; w <= fv[i].waits; w++) begin
        readyb = (w == fv[i].waits) ? 1'b0 : 1'b1;
        settle();
        check("fetch_addr", 32'(address_out), 32'(fv[i].addr));
        check("fetch_status", 32'(bus_status), 32'h9);
        check("fetch_push", 32'(queue_push), 32'(!readyb));
        if (!readyb) check("fetch_push_byte", 32'(queue_push_byte), 32'(fv[i].bytef));
        step();
      end
      readyb = 1'b1;
      settle();
      check("fetch_end_status", 32'(bus_status), 32'hF);
      step();
    end

    // EU command vectors, prefetch held off by a full queue
    for (int i = 0; i < 4; i++) begin
      queue_full = 1'b1; readyb = 1'b1;
      eu_bus_command = ev[i].cmd; eu_bus_address = ev[i].addr;
      eu_write_data = ev[i].wdata; eu_byte_enable_upper = ev[i].upper;
      tick();
      for (int w = 0; w <= ev[i].waits; w++) begin
        readyb  = (w == ev[i].waits) ? 1'b0 : 1'b1;
        data_in = (w == ev[i].waits) ? ev[i].rdata : ~ev[i].rdata;
        settle();
        check("eu_status", 32'(bus_status), 32'(ev[i].status));
        check("eu_addr", 32'(address_out), 32'(ev[i].addr));
        check("eu_upper", 32'(bus_upper_byte_enable), 32'(ev[i].upper));
        if (ev[i].cmd == 3'd2 || ev[i].cmd == 3'd4)
          check("eu_wdata", 32'(data_out), 32'(ev[i].wdata));
        step();
      end
      readyb = 1'b1;
      settle();
      check("eu_done_pulse", 32'(eu_done), 32'h1);
      if (ev[i].cmd == 3'd1 || ev[i].cmd == 3'd3)
        check("eu_rdata", 32'(eu_read_data), 32'(ev[i].rdata));
      eu_bus_command = 3'd0;
      step();
      settle();
      check("eu_done_single", 32'(eu_done), 32'h0);
      step();
    end

    // EU write against an eligible prefetch: EU first, fetch after one IDLE cycle
    do_reset();
    PS = 16'h0100; PFP = 16'h0010; queue_full = 1'b0; readyb = 1'b1;
    eu_bus_command = 3'd2; eu_bus_address = 20'h12345; eu_write_data = 16'hBEEF;
    eu_byte_enable_upper = 1'b1;
    tick();
    readyb = 1'b0;
    settle();
    check("arb_eu_first", 32'(bus_status), 32'hA);
    check("arb_wdata", 32'(data_out), 32'hBEEF);
    step();
    readyb = 1'b1;
    settle();
    check("arb_done", 32'(eu_done), 32'h1);
    eu_bus_command = 3'd0;
    step();
    readyb = 1'b0;
    settle();
    check("arb_fetch_next", 32'(bus_status), 32'h9);
    check("arb_fetch_addr", 32'(address_out), 32'h01010);
    check("arb_fetch_push", 32'(queue_push), 32'h1);
    queue_full = 1'b1;
    step();
    readyb = 1'b1;
    tick();

    // flush during a 4-wait-state fetch: word dropped, next fetch uses new PFP
    do_reset();
    PS = 16'h0000; PFP = 16'h0100; queue_full = 1'b0; readyb = 1'b1;
    tick();
    queue_full = 1'b1;
    for (int w = 0; w < 5; w++) begin
      readyb = (w == 4) ? 1'b0 : 1'b1;
      queue_flush = (w == 1) ? 1'b1 : 1'b0;
      settle();
      check("flush_no_push", 32'(queue_push), 32'h0);
      step();
    end
    queue_flush = 1'b0; readyb = 1'b1; PFP = 16'h0200; queue_full = 1'b0;
    tick();
    readyb = 1'b0;
    settle();
    check("flush_new_addr", 32'(address_out), 32'h00200);
    check("flush_next_push", 32'(queue_push), 32'h1);
    queue_full = 1'b1;
    step();
    readyb = 1'b1;
    tick();

    // starvation: four EU IO reads with prefetch pending, fifth grant is a fetch
    do_reset();
    PS = 16'h2000; PFP = 16'h0000; eu_bus_command = 3'd3; eu_bus_address = 20'h00080;
    eu_byte_enable_upper = 1'b0;
    for (int g = 1; g <= 4; g++) begin
      queue_full = 1'b0; readyb = 1'b1;
      tick();
      readyb = 1'b0; rd = 16'($urandom); data_in = rd;
      settle();
      check("starve_eu_grant", 32'(bus_status), 32'h5);
      step();
      readyb = 1'b1; queue_full = 1'b1;
      settle();
      check("starve_eu_done", 32'(eu_done), 32'h1);
      check("starve_rdata", 32'(eu_read_data), 32'(rd));
      step();
    end
    queue_full = 1'b0;
    tick();
    readyb = 1'b0;
    settle();
    check("starve_fetch", 32'(bus_status), 32'h9);
    check("starve_fetch_push", 32'(queue_push), 32'h1);
    step();
    readyb = 1'b1;
    tick();
    settle();
    check("starve_cleared_eu", 32'(bus_status), 32'h5);
    step();
    readyb = 1'b0;
    tick();
    readyb = 1'b1; queue_full = 1'b1; eu_bus_command = 3'd0;
    tick();

    // reset in the middle of an EU read: abandoned, no eu_done
    do_reset();
    queue_full = 1'b1; eu_bus_command = 3'd1; eu_bus_address = 20'h54321; readyb = 1'b1;
    tick();
    tick();
    tick();
    resetn = 1'b0; readyb = 1'b0; data_in = 16'hDEAD;
    settle();
    check("rst_mid_status", 32'(bus_status), 32'h9);
    step();
    resetn = 1'b1; readyb = 1'b1; eu_bus_command = 3'd0;
    settle();
    check("rst_mid_idle", 32'(bus_status), 32'hF);
    check("rst_mid_no_done", 32'(eu_done), 32'h0);
    check("rst_mid_addr", 32'(address_out), 32'h000FFFF0);
    step();
    settle();
    check("rst_mid_no_done2", 32'(eu_done), 32'h0);
    step();

    // long wait: aborts after TIMEOUT_CYCLES with the feature, otherwise keeps waiting
    do_reset();
    queue_full = 1'b1; eu_bus_command = 3'd3; eu_bus_address = 20'h00F00; readyb = 1'b1;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      settle();
      check("wait_status", 32'(bus_status), 32'h5);
      check("wait_no_error", 32'(bus_error), 32'h0);
      step();
    end
    settle();
`ifdef BUS_TIMEOUT_EN
    check("tmo_error", 32'(bus_error), 32'h1);
    check("tmo_done", 32'(eu_done), 32'h1);
    check("tmo_rdata", 32'(eu_read_data), 32'hFFFF);
    check("tmo_status", 32'(bus_status), 32'hF);
    eu_bus_command = 3'd0;
    step();
`else
    check("no_tmo_status", 32'(bus_status), 32'h5);
    check("no_tmo_error", 32'(bus_error), 32'h0);
    step();
    readyb = 1'b0; data_in = 16'h0F0F;
    tick();
    readyb = 1'b1; eu_bus_command = 3'd0;
    settle();
    check("no_tmo_done", 32'(eu_done), 32'h1);
    check("no_tmo_rdata", 32'(eu_read_data), 32'h0F0F);
    step();
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      resetn        = ($urandom_range(0, 99) != 0);
      PS            = 16'($urandom);
      PFP           = 16'($urandom);
      queue_full    = ($urandom_range(0, 3) == 0);
      queue_suspend = ($urandom_range(0, 7) == 0);
      queue_flush   = ($urandom_range(0, 7) == 0);
      readyb        = ($urandom_range(0, 2) == 0);
      data_in       = 16'($urandom);
      if (eu_bus_command == 3'd0 || m_done) begin
        if ($urandom_range(0, 2) == 0) begin
          eu_bus_command       = 3'($urandom_range(1, 4));
          eu_bus_address       = 20'($urandom);
          eu_write_data        = 16'($urandom);
          eu_byte_enable_upper = 1'($urandom_range(0, 1));
        end else begin
          eu_bus_command = 3'd0;
        end
      end
      tick();
    end
    resetn = 1'b1; eu_bus_command = 3'd0; queue_full = 1'b1; readyb = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
